// File: rtl/ucode_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ucode_seq_if
//  Purpose  : Bundles the fetch handshakes, the datapath status inputs and
//             the control strobes of the microcode sequencer.
//  Modports : master - fetch/datapath side (drives opcode, operand, status)
//             slave  - sequencer side (drives ready flags and strobes)
//  Signals  : op_valid/op_ready/opcode, operand_valid/operand_ready/operand,
//             w/carry/zero, alu_*/jump_*/mov_*/destination_* strobes,
//             alu_sel, sel, imm_out, jump_target, done, illegal, trap
//  Revision : 1.0 - initial release
// ============================================================================
interface ucode_seq_if #(
    parameter int DATA_W = 8
);
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        opcode;
    logic              operand_valid;
    logic              operand_ready;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] w;
    logic              carry;
    logic              zero;
    logic              alu_operation;
    logic              alu_multibyte_result;
    logic              jump_operation;
    logic              jump_condition;
    logic              mov_operation;
    logic              destination_w;
    logic              destination_flags;
    logic              destination_memory;
    logic              destination_registers;
    logic              destination_ports;
    logic [3:0]        alu_sel;
    logic [2:0]        sel;
    logic [DATA_W-1:0] imm_out;
    logic [DATA_W-1:0] jump_target;
    logic              done;
    logic              illegal;
    logic              trap;

    modport master (
        output op_valid, opcode, operand_valid, operand, w, carry, zero,
        input  op_ready, operand_ready, alu_operation, alu_multibyte_result,
               jump_operation, jump_condition, mov_operation, destination_w,
               destination_flags, destination_memory, destination_registers,
               destination_ports, alu_sel, sel, imm_out, jump_target, done,
               illegal, trap
    );

    modport slave (
        input  op_valid, opcode, operand_valid, operand, w, carry, zero,
        output op_ready, operand_ready, alu_operation, alu_multibyte_result,
               jump_operation, jump_condition, mov_operation, destination_w,
               destination_flags, destination_memory, destination_registers,
               destination_ports, alu_sel, sel, imm_out, jump_target, done,
               illegal, trap
    );
endinterface
`default_nettype wire

// File: rtl/ucode_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ucode_seq
//  Purpose  : Multi-cycle microcode sequencer between fetch and datapath.
//             Accepts an opcode, fetches an immediate for bit7=1 opcodes,
//             evaluates jump conditions and issues registered one-cycle
//             control strobes. MUL (0x8F) takes a second execute cycle.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - ucode_seq_if.slave (handshakes, status, strobes)
//  Options  : UCODE_ILLEGAL_TRAP_EN - illegal opcodes enter a sticky trap
//             state left only by rst; otherwise they behave as a NOP that
//             pulses illegal and done.
//  Revision : 1.0 - initial release
// ============================================================================
module ucode_seq #(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 8,
    parameter int NUM_PORTS = 2
) (
    input logic        clk,
    input logic        rst,
    ucode_seq_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_OPERAND = 3'd1;
    localparam logic [2:0] c_ST_EXEC    = 3'd2;
    localparam logic [2:0] c_ST_EXEC2   = 3'd3;
`ifdef UCODE_ILLEGAL_TRAP_EN
    localparam logic [2:0] c_ST_TRAP    = 3'd4;
`endif

    localparam logic [3:0] c_NUM_REGS  = 4'(NUM_REGS);
    localparam logic [3:0] c_NUM_PORTS = 4'(NUM_PORTS);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [7:0]        r_opcode;
    logic [7:0]        w_opcode;

    // decoded opcode class
    logic w_legal, w_need_opnd, w_dec_alu, w_dec_mov, w_dec_jump, w_dec_mul;
    logic w_dec_dw, w_dec_df, w_dec_dm, w_dec_dr, w_dec_dp, w_dec_sel_en;
    logic w_reg_ok, w_port_ok, w_taken;

    // registered outputs and their next values
    logic r_alu, r_multi, r_jop, r_jcond, r_mov;
    logic r_dw, r_df, r_dm, r_dr, r_dp, r_done, r_illegal;
    logic [3:0]        r_alu_sel;
    logic [2:0]        r_sel;
    logic [DATA_W-1:0] r_imm;
    logic w_alu_nxt, w_multi_nxt, w_jop_nxt, w_jcond_nxt, w_mov_nxt;
    logic w_dw_nxt, w_df_nxt, w_dm_nxt, w_dr_nxt, w_dp_nxt, w_done_nxt;
    logic w_illegal_nxt, w_issue, w_imm_load;
    logic [3:0]        w_alu_sel_nxt;
    logic [2:0]        w_sel_nxt;
`ifdef UCODE_ILLEGAL_TRAP_EN
    logic r_trap, w_trap_nxt;
`endif

    // In IDLE the opcode is decoded straight off the bus so the strobes can
    // be registered on the accepting edge; afterwards the latched copy is used.
    assign w_opcode  = (r_state == c_ST_IDLE) ? bus.opcode : r_opcode;
    assign w_reg_ok  = ({1'b0, w_opcode[2:0]} < c_NUM_REGS);
    assign w_port_ok = ({1'b0, w_opcode[2:0]} < c_NUM_PORTS);

    always_comb begin
        w_legal      = 1'b0;
        w_need_opnd  = w_opcode[7];
        w_dec_alu    = 1'b0;
        w_dec_mov    = 1'b0;
        w_dec_jump   = 1'b0;
        w_dec_mul    = 1'b0;
        w_dec_dw     = 1'b0;
        w_dec_df     = 1'b0;
        w_dec_dm     = 1'b0;
        w_dec_dr     = 1'b0;
        w_dec_dp     = 1'b0;
        w_dec_sel_en = 1'b0;
        case (w_opcode) inside
            8'h00: w_legal = 1'b1;
            [8'h01:8'h03], [8'h06:8'h0A]: begin
                w_legal = 1'b1; w_dec_alu = 1'b1; w_dec_dw = 1'b1;
            end
            8'h04, 8'h05: begin
                w_legal = 1'b1; w_dec_alu = 1'b1; w_dec_df = 1'b1;
            end
            8'h40, 8'h41: begin
                w_legal = w_port_ok; w_dec_mov = 1'b1; w_dec_dp = 1'b1; w_dec_sel_en = 1'b1;
            end
            8'h48, 8'h49: begin
                w_legal = w_port_ok; w_dec_mov = 1'b1; w_dec_dw = 1'b1; w_dec_sel_en = 1'b1;
            end
            [8'h50:8'h57]: begin
                w_legal = w_reg_ok; w_dec_mov = 1'b1; w_dec_dr = 1'b1; w_dec_sel_en = 1'b1;
            end
            [8'h58:8'h5F]: begin
                w_legal = w_reg_ok; w_dec_mov = 1'b1; w_dec_dw = 1'b1; w_dec_sel_en = 1'b1;
            end
            [8'h60:8'h6F]: begin
                w_legal = 1'b1; w_dec_alu = 1'b1; w_dec_dw = 1'b1; w_dec_sel_en = 1'b1;
            end
            [8'h80:8'h8E]: begin
                w_legal = 1'b1; w_dec_alu = 1'b1; w_dec_dw = 1'b1;
            end
            8'h8F: begin
                w_legal = 1'b1; w_dec_alu = 1'b1; w_dec_dw = 1'b1; w_dec_mul = 1'b1;
            end
            [8'h90:8'h97]: begin
                w_legal = w_reg_ok; w_dec_mov = 1'b1; w_dec_dr = 1'b1; w_dec_sel_en = 1'b1;
            end
            8'hA0: begin
                w_legal = 1'b1; w_dec_mov = 1'b1; w_dec_dm = 1'b1;
            end
            8'hA8: begin
                w_legal = 1'b1; w_dec_mov = 1'b1; w_dec_dw = 1'b1;
            end
            [8'hC0:8'hC6]: begin
                w_legal = 1'b1; w_dec_jump = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Status inputs are consumed on the edge that enters EXEC.
    always_comb begin
        w_taken = 1'b0;
        case (w_opcode[2:0])
            3'd0:    w_taken = 1'b1;
            3'd1:    w_taken = bus.carry;
            3'd2:    w_taken = !bus.carry;
            3'd3:    w_taken = bus.zero;
            3'd4:    w_taken = !bus.zero;
            3'd5:    w_taken = (bus.w == '0);
            3'd6:    w_taken = bus.w[DATA_W-1];
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_imm_load    = 1'b0;
        w_alu_nxt     = 1'b0;
        w_multi_nxt   = 1'b0;
        w_jop_nxt     = 1'b0;
        w_jcond_nxt   = 1'b0;
        w_mov_nxt     = 1'b0;
        w_dw_nxt      = 1'b0;
        w_df_nxt      = 1'b0;
        w_dm_nxt      = 1'b0;
        w_dr_nxt      = 1'b0;
        w_dp_nxt      = 1'b0;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_alu_sel_nxt = 4'd0;
        w_sel_nxt     = 3'd0;
`ifdef UCODE_ILLEGAL_TRAP_EN
        w_trap_nxt    = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (bus.op_valid) begin
                    if (!w_legal) begin
                        w_illegal_nxt = 1'b1;
`ifdef UCODE_ILLEGAL_TRAP_EN
                        w_state_nxt   = c_ST_TRAP;
                        w_trap_nxt    = 1'b1;
`else
                        w_done_nxt    = 1'b1;
`endif
                    end else if (w_need_opnd) begin
                        w_state_nxt = c_ST_OPERAND;
                    end else begin
                        w_state_nxt = c_ST_EXEC;
                        w_issue     = 1'b1;
                    end
                end
            end
            c_ST_OPERAND: begin
                if (bus.operand_valid) begin
                    w_state_nxt = c_ST_EXEC;
                    w_issue     = 1'b1;
                    w_imm_load  = 1'b1;
                end
            end
            c_ST_EXEC: begin
                if (w_dec_mul) begin
                    // high half of the product goes out on the second cycle
                    w_state_nxt   = c_ST_EXEC2;
                    w_alu_nxt     = 1'b1;
                    w_multi_nxt   = 1'b1;
                    w_df_nxt      = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_alu_sel_nxt = w_opcode[3:0];
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_EXEC2: w_state_nxt = c_ST_IDLE;
`ifdef UCODE_ILLEGAL_TRAP_EN
            c_ST_TRAP:  w_trap_nxt  = 1'b1;
`endif
            default:    w_state_nxt = c_ST_IDLE;
        endcase

        if (w_issue) begin
            w_alu_nxt     = w_dec_alu;
            w_mov_nxt     = w_dec_mov;
            w_jop_nxt     = w_dec_jump;
            w_jcond_nxt   = w_dec_jump & w_taken;
            w_dw_nxt      = w_dec_dw;
            w_df_nxt      = w_dec_df;
            w_dm_nxt      = w_dec_dm;
            w_dr_nxt      = w_dec_dr;
            w_dp_nxt      = w_dec_dp;
            w_done_nxt    = !w_dec_mul;
            w_alu_sel_nxt = w_dec_alu ? w_opcode[3:0] : 4'd0;
            w_sel_nxt     = w_dec_sel_en ? w_opcode[2:0] : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_opcode  <= 8'd0;
            r_imm     <= '0;
            r_alu     <= 1'b0;
            r_multi   <= 1'b0;
            r_jop     <= 1'b0;
            r_jcond   <= 1'b0;
            r_mov     <= 1'b0;
            r_dw      <= 1'b0;
            r_df      <= 1'b0;
            r_dm      <= 1'b0;
            r_dr      <= 1'b0;
            r_dp      <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_alu_sel <= 4'd0;
            r_sel     <= 3'd0;
`ifdef UCODE_ILLEGAL_TRAP_EN
            r_trap    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_alu     <= w_alu_nxt;
            r_multi   <= w_multi_nxt;
            r_jop     <= w_jop_nxt;
            r_jcond   <= w_jcond_nxt;
            r_mov     <= w_mov_nxt;
            r_dw      <= w_dw_nxt;
            r_df      <= w_df_nxt;
            r_dm      <= w_dm_nxt;
            r_dr      <= w_dr_nxt;
            r_dp      <= w_dp_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
            r_alu_sel <= w_alu_sel_nxt;
            r_sel     <= w_sel_nxt;
`ifdef UCODE_ILLEGAL_TRAP_EN
            r_trap    <= w_trap_nxt;
`endif
            if ((r_state == c_ST_IDLE) && bus.op_valid) begin
                r_opcode <= bus.opcode;
            end
            if (w_imm_load) begin
                r_imm <= bus.operand;
            end
        end
    end

    assign bus.op_ready             = (r_state == c_ST_IDLE);
    assign bus.operand_ready        = (r_state == c_ST_OPERAND);
    assign bus.alu_operation        = r_alu;
    assign bus.alu_multibyte_result = r_multi;
    assign bus.jump_operation       = r_jop;
    assign bus.jump_condition       = r_jcond;
    assign bus.mov_operation        = r_mov;
    assign bus.destination_w        = r_dw;
    assign bus.destination_flags    = r_df;
    assign bus.destination_memory   = r_dm;
    assign bus.destination_registers = r_dr;
    assign bus.destination_ports    = r_dp;
    assign bus.alu_sel              = r_alu_sel;
    assign bus.sel                  = r_sel;
    assign bus.imm_out              = r_imm;
    assign bus.jump_target          = r_imm;
    assign bus.done                 = r_done;
    assign bus.illegal              = r_illegal;
`ifdef UCODE_ILLEGAL_TRAP_EN
    assign bus.trap                 = r_trap;
`else
    assign bus.trap                 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ucode_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucode_seq
//  Purpose  : Directed self-checking bench for ucode_seq. Expected output
//             snapshots are queued as stimulus is driven and compared when
//             the sequencer responds. A second instance with NUM_REGS=2
//             exercises register-index legality.
//  Options  : UCODE_ILLEGAL_TRAP_EN selects the trap expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ucode_seq;

    typedef struct packed {
        logic       op_ready;
        logic       operand_ready;
        logic       alu;
        logic       multi;
        logic       jop;
        logic       jcond;
        logic       mov;
        logic       dw;
        logic       df;
        logic       dm;
        logic       dr;
        logic       dp;
        logic [3:0] alu_sel;
        logic [2:0] sel;
        logic [7:0] imm;
        logic [7:0] jt;
        logic       done;
        logic       illegal;
        logic       trap;
    } obs_t;

    logic clk;
    logic rst;
    int   n_asrt;
    int   n_fail;
    logic [7:0] cur_imm;
    obs_t e;
    obs_t o1;
    obs_t o2;
    obs_t exp_q[$];
    obs_t exp2_q[$];

    ucode_seq_if #(.DATA_W(8)) bus ();
    ucode_seq_if #(.DATA_W(8)) bus2 ();

    ucode_seq #(.DATA_W(8), .NUM_REGS(8), .NUM_PORTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ucode_seq #(.DATA_W(8), .NUM_REGS(2), .NUM_PORTS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o1 = '0;
        o1.op_ready = bus.op_ready;           o1.operand_ready = bus.operand_ready;
        o1.alu      = bus.alu_operation;      o1.multi   = bus.alu_multibyte_result;
        o1.jop      = bus.jump_operation;     o1.jcond   = bus.jump_condition;
        o1.mov      = bus.mov_operation;      o1.dw      = bus.destination_w;
        o1.df       = bus.destination_flags;  o1.dm      = bus.destination_memory;
        o1.dr       = bus.destination_registers; o1.dp   = bus.destination_ports;
        o1.alu_sel  = bus.alu_sel;            o1.sel     = bus.sel;
        o1.imm      = bus.imm_out;            o1.jt      = bus.jump_target;
        o1.done     = bus.done;               o1.illegal = bus.illegal;
        o1.trap     = bus.trap;
    end

    always_comb begin
        o2 = '0;
        o2.op_ready = bus2.op_ready;          o2.operand_ready = bus2.operand_ready;
        o2.alu      = bus2.alu_operation;     o2.multi   = bus2.alu_multibyte_result;
        o2.jop      = bus2.jump_operation;    o2.jcond   = bus2.jump_condition;
        o2.mov      = bus2.mov_operation;     o2.dw      = bus2.destination_w;
        o2.df       = bus2.destination_flags; o2.dm      = bus2.destination_memory;
        o2.dr       = bus2.destination_registers; o2.dp  = bus2.destination_ports;
        o2.alu_sel  = bus2.alu_sel;           o2.sel     = bus2.sel;
        o2.imm      = bus2.imm_out;           o2.jt      = bus2.jump_target;
        o2.done     = bus2.done;              o2.illegal = bus2.illegal;
        o2.trap     = bus2.trap;
    end

    // Outputs are sampled 1 ns after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t idle_e();
        obs_t x = '0;
        x.op_ready = 1'b1;
        x.imm      = cur_imm;
        x.jt       = cur_imm;
        return x;
    endfunction

    function automatic obs_t busy_e();
        obs_t x = '0;
        x.imm = cur_imm;
        x.jt  = cur_imm;
        return x;
    endfunction

    task automatic chk(input string tag);
        obs_t ex;
        ex = exp_q.pop_front();
        n_asrt++;
        assert (o1 === ex) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o1, ex);
        end
    endtask

    task automatic chk2(input string tag);
        obs_t ex;
        ex = exp2_q.pop_front();
        n_asrt++;
        assert (o2 === ex) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o2, ex);
        end
    endtask

    task automatic to_idle(input string tag);
        exp_q.push_back(idle_e());
        tick();
        chk(tag);
    endtask

    // No-operand instruction: response on the cycle after acceptance.
    task automatic run_noop(input logic [7:0] op, input obs_t ex, input string tag);
        bus.opcode   = op;
        bus.op_valid = 1'b1;
        exp_q.push_back(ex);
        tick();
        bus.op_valid = 1'b0;
        chk(tag);
        to_idle({tag, "_idle"});
    endtask

    // Operand instruction: operand_ready observed for 'delay' cycles before
    // the operand is presented; the execute snapshot follows one cycle later.
    task automatic run_op(input logic [7:0] op, input logic [7:0] opnd,
                          input int delay, input obs_t ex, input string tag);
        obs_t wt;
        bus.opcode   = op;
        bus.op_valid = 1'b1;
        wt = busy_e();
        wt.operand_ready = 1'b1;
        for (int i = 0; i < delay; i++) begin
            exp_q.push_back(wt);
            tick();
            bus.op_valid = 1'b0;
            chk({tag, "_wait"});
        end
        bus.operand       = opnd;
        bus.operand_valid = 1'b1;
        cur_imm = opnd;
        ex.imm  = opnd;
        ex.jt   = opnd;
        exp_q.push_back(ex);
        tick();
        bus.operand_valid = 1'b0;
        chk(tag);
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        cur_imm = 8'h00;
        rst = 1'b1;
        bus.op_valid = 1'b0;  bus.opcode = 8'h00;  bus.operand_valid = 1'b0;
        bus.operand = 8'h00;  bus.w = 8'h00;       bus.carry = 1'b0;  bus.zero = 1'b0;
        bus2.op_valid = 1'b0; bus2.opcode = 8'h00; bus2.operand_valid = 1'b0;
        bus2.operand = 8'h00; bus2.w = 8'h00;      bus2.carry = 1'b0; bus2.zero = 1'b0;

        tick();
        tick();
        exp_q.push_back(idle_e());
        chk("reset_hold");
        rst = 1'b0;
        tick();
        exp_q.push_back(idle_e());
        chk("reset_release");

        // ALU register ops
        e = busy_e(); e.alu = 1'b1; e.dw = 1'b1; e.alu_sel = 4'h2; e.done = 1'b1;
        run_noop(8'h02, e, "op02");
        e = busy_e(); e.alu = 1'b1; e.df = 1'b1; e.alu_sel = 4'h5; e.done = 1'b1;
        run_noop(8'h05, e, "op05");
        e = busy_e(); e.done = 1'b1;
        run_noop(8'h00, e, "nop");
        // moves and bit ops carry an index in sel
        e = busy_e(); e.mov = 1'b1; e.dr = 1'b1; e.sel = 3'd3; e.done = 1'b1;
        run_noop(8'h53, e, "op53");
        e = busy_e(); e.mov = 1'b1; e.dp = 1'b1; e.sel = 3'd1; e.done = 1'b1;
        run_noop(8'h41, e, "op41");
        e = busy_e(); e.alu = 1'b1; e.dw = 1'b1; e.alu_sel = 4'hA; e.sel = 3'd2; e.done = 1'b1;
        run_noop(8'h6A, e, "op6A");

        // register index 3 is out of range when only two registers exist
        bus2.opcode   = 8'h53;
        bus2.op_valid = 1'b1;
        e = '0;
        e.illegal = 1'b1;
`ifdef UCODE_ILLEGAL_TRAP_EN
        e.trap = 1'b1;
`else
        e.op_ready = 1'b1;
        e.done     = 1'b1;
`endif
        exp2_q.push_back(e);
        tick();
        bus2.op_valid = 1'b0;
        chk2("nregs2_op53");

        // jumps with a delayed operand
        bus.carry = 1'b1;
        e = busy_e(); e.jop = 1'b1; e.jcond = 1'b1; e.done = 1'b1;
        run_op(8'hC1, 8'h3C, 3, e, "jc_taken");
        to_idle("jc_taken_idle");
        bus.carry = 1'b0;
        e = busy_e(); e.jop = 1'b1; e.jcond = 1'b0; e.done = 1'b1;
        run_op(8'hC1, 8'h44, 1, e, "jc_not");
        to_idle("jc_not_idle");
        bus.w = 8'h00;
        e = busy_e(); e.jop = 1'b1; e.jcond = 1'b1; e.done = 1'b1;
        run_op(8'hC5, 8'h12, 1, e, "jwz_taken");
        to_idle("jwz_taken_idle");
        bus.w = 8'h01;
        e = busy_e(); e.jop = 1'b1; e.jcond = 1'b0; e.done = 1'b1;
        run_op(8'hC5, 8'h13, 1, e, "jwz_not");
        to_idle("jwz_not_idle");
        bus.w = 8'h80;
        e = busy_e(); e.jop = 1'b1; e.jcond = 1'b1; e.done = 1'b1;
        run_op(8'hC6, 8'h21, 1, e, "jwn_taken");
        to_idle("jwn_taken_idle");
        bus.w = 8'h00;

        // ALU immediate and memory store
        e = busy_e(); e.alu = 1'b1; e.dw = 1'b1; e.alu_sel = 4'h3; e.done = 1'b1;
        run_op(8'h83, 8'hA5, 2, e, "op83");
        to_idle("op83_idle");
        e = busy_e(); e.mov = 1'b1; e.dm = 1'b1; e.done = 1'b1;
        run_op(8'hA0, 8'h5A, 1, e, "opA0");
        to_idle("opA0_idle");

        // MUL: two execute cycles, done only on the second
        e = busy_e(); e.alu = 1'b1; e.dw = 1'b1; e.alu_sel = 4'hF;
        run_op(8'h8F, 8'h05, 1, e, "mul_exec");
        e = busy_e(); e.alu = 1'b1; e.multi = 1'b1; e.df = 1'b1; e.alu_sel = 4'hF; e.done = 1'b1;
        exp_q.push_back(e);
        tick();
        chk("mul_exec2");
        to_idle("mul_idle");

`ifndef UCODE_ILLEGAL_TRAP_EN
        e = idle_e(); e.illegal = 1'b1; e.done = 1'b1;
        run_noop(8'hC7, e, "opC7_illegal");
`endif

        // reset while waiting for an operand aborts without done
        bus.opcode   = 8'h80;
        bus.op_valid = 1'b1;
        e = busy_e(); e.operand_ready = 1'b1;
        exp_q.push_back(e);
        tick();
        bus.op_valid = 1'b0;
        chk("rst_opnd_wait");
        rst = 1'b1;
        bus.operand       = 8'h77;
        bus.operand_valid = 1'b1;
        cur_imm = 8'h00;
        exp_q.push_back(idle_e());
        tick();
        chk("rst_abort");
        rst = 1'b0;
        bus.operand_valid = 1'b0;
        to_idle("rst_after");

        // undefined opcode
        bus.opcode   = 8'hFF;
        bus.op_valid = 1'b1;
`ifdef UCODE_ILLEGAL_TRAP_EN
        e = busy_e(); e.illegal = 1'b1; e.trap = 1'b1;
        exp_q.push_back(e);
        tick();
        bus.opcode = 8'h00;
        chk("trap_enter");
        e = busy_e(); e.trap = 1'b1;
        exp_q.push_back(e);
        tick();
        chk("trap_sticky1");
        exp_q.push_back(e);
        tick();
        bus.op_valid = 1'b0;
        chk("trap_sticky2");
        rst = 1'b1;
        exp_q.push_back(idle_e());
        tick();
        chk("trap_rst");
        rst = 1'b0;
        to_idle("trap_cleared");
`else
        e = idle_e(); e.illegal = 1'b1; e.done = 1'b1;
        exp_q.push_back(e);
        tick();
        bus.op_valid = 1'b0;
        chk("opFF_illegal");
        to_idle("opFF_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucode_seq.md
Name: ucode_seq

Overview:
- Parametrised successor to the single-cycle opcode decoder: a multi-cycle microcode sequencer for the CPU core.
- Accepts opcodes from fetch with a valid/ready handshake and fetches an immediate operand when the opcode class needs one.
- Evaluates jump conditions from carry, zero and W, then issues registered one-cycle control strobes to the ALU, register file, ports and memory.
- Sits between the fetch unit and the datapath.

Parameters:
- DATA_W, 8, width of w, operand, jump_target and imm_out.
- NUM_REGS, 8, implemented registers (2..8); a register index >= NUM_REGS is illegal.
- NUM_PORTS, 2, implemented ports (1..2); a port index >= NUM_PORTS is illegal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  fetch presents opcode.
- op_ready  out  1  sequencer accepts opcode; equals (state==IDLE).
- opcode  in  8  instruction opcode.
- operand_valid  in  1  fetch presents immediate.
- operand_ready  out  1  equals (state==OPERAND).
- operand  in  DATA_W  immediate byte.
- w, carry, zero  in  DATA_W,1,1  datapath status.
- alu_operation, alu_multibyte_result, jump_operation, jump_condition, mov_operation  out  1 each  control strobes.
- destination_w, destination_flags, destination_memory, destination_registers, destination_ports  out  1 each  destination strobes.
- alu_sel  out  4  equals opcode[3:0] on ALU ops.
- sel  out  3  register, port or bit index (opcode[2:0]).
- imm_out, jump_target  out  DATA_W  latched immediate.
- done  out  1  one-cycle pulse when the instruction completes.
- illegal  out  1  one-cycle pulse for an undefined opcode.
- trap  out  1  see Optional Feature.

Behaviour:
- States are IDLE, OPERAND, EXEC, EXEC2.
- Reset: state goes to IDLE; every registered output clears to 0, including imm_out and jump_target. op_ready=1 in the first cycle after rst deasserts.
- Reset mid-instruction: abort, no done pulse, strobes are 0 on the next cycle.
- IDLE: on op_valid&&op_ready, latch the opcode.
  - Opcode with bit7=1 goes to OPERAND.
  - Otherwise it goes to EXEC.
  - Undefined opcode: pulse illegal and done for one cycle with all strobes 0, then stay in IDLE.
- OPERAND: wait indefinitely; on operand_valid, latch operand into imm_out and jump_target, then go to EXEC.
- Entering EXEC: sample carry, zero and w on the same edge.
- EXEC: strobes and done are asserted for exactly one cycle, then the state returns to IDLE.
  - Exception: 0x8F (MUL) goes to EXEC2, with done held off until EXEC2.
- Latency:
  - No-operand instruction: accept at cycle N, strobes at N+1, op_ready at N+2.
  - Operand instruction: strobes one cycle after operand_valid is accepted.
- Opcode map (all others illegal):
  - 0x00 NOP: done only.
  - 0x01-0x03, 0x06-0x0A: alu_operation + destination_w.
  - 0x04, 0x05: alu_operation + destination_flags.
  - 0x40-0x41 MovWP: mov + destination_ports.
  - 0x48-0x49 MovPW: mov + destination_w.
  - 0x50-0x57 MovWR: mov + destination_registers.
  - 0x58-0x5F MovRW: mov + destination_w.
  - 0x60-0x6F SetbW/ClrbW: alu + destination_w, with sel = bit index.
  - 0x80-0x8E ALU-immediate: alu + destination_w.
  - 0x8F MUL: EXEC = alu + destination_w; EXEC2 = alu + alu_multibyte_result + destination_flags + done.
  - 0x90-0x97 MovIR: mov + destination_registers.
  - 0xA0 MovWM: mov + destination_memory.
  - 0xA8 MovMW: mov + destination_w.
  - 0xC0-0xC6 jumps: jump_operation=1, with jump_condition = taken.
- Jump conditions by opcode[2:0]: 0 always, 1 carry, 2 !carry, 3 zero, 4 !zero, 5 w==0, 6 w[DATA_W-1]. 0xC7 is illegal.
- Simultaneous op_valid in a non-IDLE state is not accepted; fetch must hold it.

Optional Feature:
- Macro: UCODE_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode enters a sticky TRAP state.
  - trap=1; op_ready=0 and operand_ready=0.
  - illegal pulses once; no done pulse.
  - Only rst exits TRAP.
- Undefined: illegal is a one-cycle pulse treated as NOP, and trap is tied to 0.

Test Plan:
- Reset, then opcode 0x02 with op_valid=1 → cycle+1: alu_operation=1, destination_w=1, alu_sel=2, done=1; cycle+2: all 0, op_ready=1.
- 0x53 with NUM_REGS=8 → mov_operation=1, destination_registers=1, sel=3. Same opcode with NUM_REGS=2 → illegal=1, no strobes.
- 0xC1 with operand 0x3C delayed 3 cycles, carry=1 → operand_ready held 3 cycles; then jump_operation=1, jump_condition=1, jump_target=0x3C. With carry=0 → jump_condition=0.
- 0xC5 with w=0x00 → taken; w=0x01 → not taken. 0xC6 with w=0x80 → taken.
- 0x8F with operand 0x05 → EXEC: alu + destination_w, done=0; next cycle: alu_multibyte_result=1, destination_flags=1, done=1.
- rst asserted while in OPERAND → next cycle IDLE, no done pulse. Then opcode 0xFF → illegal pulse; with UCODE_ILLEGAL_TRAP_EN, trap=1 and op_ready=0 until rst.
